reg_wb_arbiter: RTL and testbench
=================================

// Module: reg_wb_arbiter
// PURPOSE
// - Shares the register file's single write port (rd_addr/rd_data/rd_wr_en) between two writeback sources: ALU (alu_*) and load/store unit (lsu_*).
// - Uses valid/ready handshakes, LSU-first priority and an ALU anti-starvation counter.
// - Drives the register file write port from a one-entry registered write stage. Sits between the writeback stage and the register file.
// PARAMETERS
// - MAX_WAIT  4  max consecutive cycles a valid ALU request may lose arbitration; min 1
// - CNT_W     $clog2(MAX_WAIT+1)  localparam, wait-counter width
// PORTS
// - clk          in   1   clock
// - rst          in   1   reset, synchronous, active-high
// - clk_en       in   1   clock enable, shared with the register file
// - alu_valid    in   1   ALU writeback request
// - alu_ready    out  1   ALU request accepted this cycle
// - alu_addr     in   5   regAddr_t destination
// - alu_data     in   32  dataBus_u result
// - lsu_valid    in   1   LSU (load) writeback request
// - lsu_ready    out  1   LSU request accepted this cycle
// - lsu_addr     in   5   regAddr_t destination
// - lsu_data     in   32  dataBus_u load data
// - rd_addr      out  5   to register file write address
// - rd_data      out  32  to register file write data
// - rd_wr_en     out  1   to register file write enable
// - grant_src    out  1   wb_src_e of the write currently in the stage (debug/trace)
// BEHAVIOUR
// - Reset (rst=1 at posedge):
//   - wq_valid=0, rd_addr=0, rd_data=0, grant_src=WB_SRC_ALU, wait_cnt=0.
//   - alu_ready=lsu_ready=0 while rst=1.
// - Handshake:
//   - Transfer on valid&ready. Ready is combinational from valid, clk_en and wait_cnt.
//   - Once asserted, valid and payload are held stable by the source until ready.
// - Arbitration, when clk_en=1 and rst=0:
//   - Only LSU valid -> LSU granted.
//   - Only ALU valid -> ALU granted.
//   - Both valid -> LSU granted, unless wait_cnt==MAX_WAIT, in which case ALU is granted.
//   - Exactly one ready per cycle, at most.
// - wait_cnt:
//   - +1, saturating at MAX_WAIT, when alu_valid=1 and ALU is not granted.
//   - Cleared when ALU is granted or alu_valid=0.
//   - Held when clk_en=0.
// - Write stage:
//   - On grant, at the next posedge, wq_valid=1, rd_addr/rd_data=winner payload, grant_src=winner.
//   - With no grant and clk_en=1, wq_valid=0.
//   - clk_en=0 -> all state holds.
// - rd_wr_en = wq_valid & (rd_addr!=0). Writes to x0 are accepted (ready=1) and dropped.
// - Latency: accept at edge N -> rd_wr_en=1 during cycle N+1 -> register file updated at edge N+1.
// - Throughput: one write per clk_en cycle; back-to-back grants are allowed.
// - Same rd address from both sources in the same cycle: only the winner writes. The loser writes on a later cycle, so its value is the final one.
// - clk_en low mid-request: ready=0, counter frozen, request stays pending.
// - Reset mid-operation: pending write in the stage is discarded, not written.
// CONFIGURATION
// - RF_WB_BYPASS_EN defined:
//   - Adds rs1_addr/rs2_addr (in, 5), rs1_rf/rs2_rf (in, 32; from register file) and rs1_fwd/rs2_fwd (out, 32).
//   - rsX_fwd = (wq_valid & rd_addr!=0 & rd_addr==rsX_addr) ? rd_data : rsX_rf. Purely combinational.
//   - Removes the read-after-write bubble.
// - RF_WB_BYPASS_EN undefined: these ports and that logic are absent. Decode stalls one cycle on a pending-write address match.
// STRUCTURE
// - Shared package riscv_definitions: regAddr_t, dataBus_u, new enum wb_src_e {WB_SRC_ALU=0, WB_SRC_LSU=1}.
// - Single module, no sub-modules: arbiter comb block, wait counter, write-stage register, optional bypass mux.
// TESTING
// - Reset: assert rst 2 cycles with both valids high -> readys 0, rd_wr_en 0, rd_addr 0.
// - Single ALU write: alu x5=0xDEADBEEF -> alu_ready same cycle; next cycle rd_wr_en=1, rd_addr=5, rd_data=0xDEADBEEF.
// - Contention: both valid, ALU x3, LSU x4 held -> LSU first. With MAX_WAIT=4 and LSU re-requesting every cycle, ALU granted on 5th cycle, wait_cnt back to 0.
// - x0 write: lsu_addr=0, data 0x1234 -> lsu_ready=1; next cycle rd_wr_en=0.
// - clk_en gating: drop clk_en for 3 cycles during a pending ALU request -> no ready, stage and counter hold; grant on first cycle clk_en=1.
// - Bypass (RF_WB_BYPASS_EN): write x7=0x55 pending, rs1_addr=7, rs1_rf=0x0 -> rs1_fwd=0x55. With rs1_addr=0 -> rs1_fwd=rs1_rf.

Source files
------------

// File: rtl/reg_wb_arbiter_pkg.sv
// rtl/reg_wb_arbiter_pkg.sv - shared writeback types: register address, data bus, writeback source
package reg_wb_arbiter_pkg;

    typedef logic [4:0] regAddr_t;

    typedef union packed {
        logic [31:0]     word;
        logic [3:0][7:0] bytes;
    } dataBus_u;

    typedef enum logic {
        WB_SRC_ALU = 1'b0,
        WB_SRC_LSU = 1'b1
    } wb_src_e;

endpackage

// File: rtl/reg_wb_arbiter_if.sv
// rtl/reg_wb_arbiter_if.sv - writeback request channels and register-file write port
interface reg_wb_arbiter_if;
    import reg_wb_arbiter_pkg::*;

    logic     alu_valid;
    logic     alu_ready;
    regAddr_t alu_addr;
    dataBus_u alu_data;

    logic     lsu_valid;
    logic     lsu_ready;
    regAddr_t lsu_addr;
    dataBus_u lsu_data;

    regAddr_t rd_addr;
    dataBus_u rd_data;
    logic     rd_wr_en;
    wb_src_e  grant_src;

    modport master (
        output alu_valid, alu_addr, alu_data,
        output lsu_valid, lsu_addr, lsu_data,
        input  alu_ready, lsu_ready,
        input  rd_addr, rd_data, rd_wr_en, grant_src
    );

    modport slave (
        input  alu_valid, alu_addr, alu_data,
        input  lsu_valid, lsu_addr, lsu_data,
        output alu_ready, lsu_ready,
        output rd_addr, rd_data, rd_wr_en, grant_src
    );

endinterface

// File: rtl/reg_wb_arbiter.sv
// rtl/reg_wb_arbiter.sv - LSU-first writeback arbiter with ALU anti-starvation and one-entry write stage
// Optional register-read bypass from the write stage when RF_WB_BYPASS_EN is defined.
module reg_wb_arbiter
    import reg_wb_arbiter_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_en,
`ifdef RF_WB_BYPASS_EN
    input  regAddr_t         rs1_addr,
    input  regAddr_t         rs2_addr,
    input  dataBus_u         rs1_rf,
    input  dataBus_u         rs2_rf,
    output dataBus_u         rs1_fwd,
    output dataBus_u         rs2_fwd,
`endif
    reg_wb_arbiter_if.slave  bus
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             alu_grant;
    logic             lsu_grant;
    logic             wq_valid;
    regAddr_t         wq_addr;
    dataBus_u         wq_data;
    wb_src_e          wq_src;

    // LSU wins ties until the ALU has lost MAX_WAIT times in a row.
    always_comb begin
        alu_grant = 1'b0;
        lsu_grant = 1'b0;
        if (clk_en && !rst) begin
            alu_grant = bus.alu_valid &&
                        (!bus.lsu_valid || wait_cnt == CNT_W'(MAX_WAIT));
            lsu_grant = bus.lsu_valid && !alu_grant;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
            wq_valid <= 1'b0;
            wq_addr  <= '0;
            wq_data  <= '0;
            wq_src   <= WB_SRC_ALU;
        end else if (clk_en) begin
            if (!bus.alu_valid || alu_grant)
                wait_cnt <= '0;
            else if (wait_cnt != CNT_W'(MAX_WAIT))
                wait_cnt <= wait_cnt + 1'b1;

            wq_valid <= alu_grant || lsu_grant;
            if (lsu_grant) begin
                wq_addr <= bus.lsu_addr;
                wq_data <= bus.lsu_data;
                wq_src  <= WB_SRC_LSU;
            end else if (alu_grant) begin
                wq_addr <= bus.alu_addr;
                wq_data <= bus.alu_data;
                wq_src  <= WB_SRC_ALU;
            end
        end
    end

    assign bus.alu_ready = alu_grant;
    assign bus.lsu_ready = lsu_grant;
    assign bus.rd_addr   = wq_addr;
    assign bus.rd_data   = wq_data;
    assign bus.grant_src = wq_src;
    // x0 writes are accepted upstream but never reach the register file.
    assign bus.rd_wr_en  = wq_valid && (wq_addr != '0);

`ifdef RF_WB_BYPASS_EN
    assign rs1_fwd = (bus.rd_wr_en && wq_addr == rs1_addr) ? wq_data : rs1_rf;
    assign rs2_fwd = (bus.rd_wr_en && wq_addr == rs2_addr) ? wq_data : rs2_rf;
`endif

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// tb/tb_reg_wb_arbiter.sv - directed self-checking bench for reg_wb_arbiter (RF_WB_BYPASS_EN aware)
module tb_reg_wb_arbiter;
    import reg_wb_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic clk_en;
    int   n_tests = 0;
    int   n_fail  = 0;

    reg_wb_arbiter_if bus ();

`ifdef RF_WB_BYPASS_EN
    regAddr_t rs1_addr, rs2_addr;
    dataBus_u rs1_rf, rs2_rf, rs1_fwd, rs2_fwd;
`endif

    reg_wb_arbiter #(.MAX_WAIT(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .clk_en   (clk_en),
`ifdef RF_WB_BYPASS_EN
        .rs1_addr (rs1_addr),
        .rs2_addr (rs2_addr),
        .rs1_rf   (rs1_rf),
        .rs2_rf   (rs2_rf),
        .rs1_fwd  (rs1_fwd),
        .rs2_fwd  (rs2_fwd),
`endif
        .bus      (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ready(input string tag, input logic alu_r, input logic lsu_r);
        check({tag, ".alu_ready"}, 32'(bus.alu_ready), 32'(alu_r));
        check({tag, ".lsu_ready"}, 32'(bus.lsu_ready), 32'(lsu_r));
    endtask

    task automatic check_stage(input string tag, input logic wr_en, input logic [4:0] addr,
                               input logic [31:0] data, input logic src);
        check({tag, ".rd_wr_en"},  32'(bus.rd_wr_en),  32'(wr_en));
        check({tag, ".rd_addr"},   32'(bus.rd_addr),   32'(addr));
        check({tag, ".rd_data"},   bus.rd_data,        data);
        check({tag, ".grant_src"}, 32'(bus.grant_src), 32'(src));
    endtask

    task automatic set_alu(input logic v, input logic [4:0] a, input logic [31:0] d);
        bus.alu_valid = v;
        bus.alu_addr  = a;
        bus.alu_data  = d;
    endtask

    task automatic set_lsu(input logic v, input logic [4:0] a, input logic [31:0] d);
        bus.lsu_valid = v;
        bus.lsu_addr  = a;
        bus.lsu_data  = d;
    endtask

    initial begin
        rst    = 1'b1;
        clk_en = 1'b1;
        set_alu(1'b1, 5'd1, 32'h1111_1111);
        set_lsu(1'b1, 5'd2, 32'h2222_2222);
`ifdef RF_WB_BYPASS_EN
        rs1_addr = '0; rs2_addr = '0; rs1_rf = '0; rs2_rf = '0;
`endif
        #1;
        for (int i = 0; i < 2; i++) begin
            check_ready("reset", 1'b0, 1'b0);
            tick();
            check_stage("reset", 1'b0, 5'd0, 32'h0, WB_SRC_ALU);
        end

        // Single ALU write
        rst = 1'b0;
        set_lsu(1'b0, 5'd0, 32'h0);
        set_alu(1'b1, 5'd5, 32'hDEAD_BEEF);
        #1 check_ready("alu_single", 1'b1, 1'b0);
        tick();
        set_alu(1'b0, 5'd0, 32'h0);
        check_stage("alu_single", 1'b1, 5'd5, 32'hDEAD_BEEF, WB_SRC_ALU);
        #1 check_ready("idle", 1'b0, 1'b0);
        tick();
        check("idle.rd_wr_en", 32'(bus.rd_wr_en), 32'h0);

`ifdef RF_WB_BYPASS_EN
        set_alu(1'b1, 5'd7, 32'h55);
        tick();
        set_alu(1'b0, 5'd0, 32'h0);
        rs1_addr = 5'd7; rs1_rf = 32'h0;
        rs2_addr = 5'd8; rs2_rf = 32'h77;
        #1;
        check("bypass.rs1_hit",  rs1_fwd, 32'h55);
        check("bypass.rs2_miss", rs2_fwd, 32'h77);
        rs1_addr = 5'd0; rs1_rf = 32'h99;
        #1 check("bypass.rs1_x0", rs1_fwd, 32'h99);
        tick();
`endif

        // Contention: LSU wins four times, ALU on the fifth
        set_alu(1'b1, 5'd3, 32'hAAAA_0003);
        set_lsu(1'b1, 5'd4, 32'hBBBB_0004);
        for (int i = 0; i < 4; i++) begin
            #1 check_ready("contend_lsu", 1'b0, 1'b1);
            tick();
            check_stage("contend_lsu", 1'b1, 5'd4, 32'hBBBB_0004, WB_SRC_LSU);
        end
        #1 check_ready("contend_alu", 1'b1, 1'b0);
        tick();
        check_stage("contend_alu", 1'b1, 5'd3, 32'hAAAA_0003, WB_SRC_ALU);
        set_alu(1'b1, 5'd6, 32'hAAAA_0006);
        #1 check_ready("contend_cnt_cleared", 1'b0, 1'b1);
        tick();
        check_stage("contend_after", 1'b1, 5'd4, 32'hBBBB_0004, WB_SRC_LSU);

        // x0 write is accepted but not written
        set_alu(1'b0, 5'd0, 32'h0);
        set_lsu(1'b1, 5'd0, 32'h1234);
        #1 check_ready("x0", 1'b0, 1'b1);
        tick();
        check_stage("x0", 1'b0, 5'd0, 32'h1234, WB_SRC_LSU);

        // clk_en gating with the wait counter at 3
        set_alu(1'b1, 5'd10, 32'hA0);
        set_lsu(1'b1, 5'd11, 32'hB0);
        for (int i = 0; i < 3; i++) tick();
        check_stage("gate_pre", 1'b1, 5'd11, 32'hB0, WB_SRC_LSU);
        clk_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 check_ready("gate_off", 1'b0, 1'b0);
            tick();
            check_stage("gate_hold", 1'b1, 5'd11, 32'hB0, WB_SRC_LSU);
        end
        clk_en = 1'b1;
        #1 check_ready("gate_on_lsu", 1'b0, 1'b1);
        tick();
        check_ready("gate_on_alu", 1'b1, 1'b0);
        tick();
        check_stage("gate_alu", 1'b1, 5'd10, 32'hA0, WB_SRC_ALU);

        // Lone ALU request held across clk_en low, granted on re-enable
        set_lsu(1'b0, 5'd0, 32'h0);
        set_alu(1'b1, 5'd12, 32'hC0);
        clk_en = 1'b0;
        #1 check_ready("alu_gate_off", 1'b0, 1'b0);
        tick();
        clk_en = 1'b1;
        #1 check_ready("alu_gate_on", 1'b1, 1'b0);
        tick();
        check_stage("alu_gate", 1'b1, 5'd12, 32'hC0, WB_SRC_ALU);

        // Reset with a write pending in the stage
        set_alu(1'b1, 5'd9, 32'h9999);
        tick();
        check("rst_mid.pending", 32'(bus.rd_wr_en), 32'h1);
        rst = 1'b1;
        #1 check_ready("rst_mid", 1'b0, 1'b0);
        tick();
        check_stage("rst_mid", 1'b0, 5'd0, 32'h0, WB_SRC_ALU);
        rst = 1'b0;
        set_alu(1'b0, 5'd0, 32'h0);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
